// File: rtl/uart_rx_sipo.sv
// -----------------------------------------------------------------------------
// uart_rx_sipo
//
// 8N1 UART receiver with serial-in / parallel-out valid/ready output stage.
//
// The serial line is double-flopped (s_ser) before any use. A 1->0 edge on
// s_ser in IDLE starts a frame. The bit-timing counter then expires at
// mid start bit, at the middle of each of the 8 data bits, and at mid stop bit.
// The FSM is in START with the counter at CLKS_PER_BIT/2-1 on the first cycle
// after the edge is seen. Counting from that cycle, the mid-stop decision is
// taken CLKS_PER_BIT/2-1 + 9*CLKS_PER_BIT cycles later (151 at 16 clocks/bit).
// The byte is presented one cycle after that.
//
// Output handshake: p_valid/p_ready. A byte is transferred on every cycle
// where p_valid && p_ready. p_out is held stable while p_valid is high, and
// p_valid never drops without a transfer. A new good frame may reload the
// register in the same cycle as a transfer. If it completes while the
// consumer is stalling, the new byte is dropped and overrun pulses.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (even, 4..1024)
//   MSB_FIRST     1: first data bit lands in p_out[7]; 0: in p_out[0]
//
// Ports:
//   clk        clock, rising edge
//   clr        synchronous active-high reset, highest priority
//   ser        asynchronous serial input, idles high
//   rx_inh     freezes FSM, counters and shift register; blocks new starts
//   p_out      received byte
//   p_valid    byte available
//   p_ready    consumer accepts the byte
//   busy       FSM is not in IDLE
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    one-cycle pulse when a good byte is dropped
//   dbg_state  current FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// -----------------------------------------------------------------------------
module uart_rx_sipo #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ser,
  input  logic       rx_inh,
  output logic [7:0] p_out,
  output logic       p_valid,
  input  logic       p_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q;
  logic          sync1_q;
  logic          s_ser_q;
  logic          prev_q;
  // Marks which of sync1_q / s_ser_q / prev_q hold real line samples since
  // reset. Without it, the reset value 1 in the flops followed by a line
  // that is already low would look like a start edge.
  logic [2:0]    vld_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    sr_q;
  logic [7:0]    sr_d;
  logic [7:0]    p_out_q;
  logic          p_valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  logic cnt_exp;
  logic start_edge;
  logic good_frame;
  logic bad_frame;
  logic accept;

  always_comb begin
    cnt_exp    = (cnt_q == '0);
    start_edge = vld_q[2] & prev_q & ~s_ser_q;
    good_frame = !rx_inh && (state_q == STOP) && cnt_exp &&  s_ser_q;
    bad_frame  = !rx_inh && (state_q == STOP) && cnt_exp && !s_ser_q;
    accept     = p_valid_q && p_ready;
    sr_d       = MSB_FIRST ? {sr_q[6:0], s_ser_q} : {s_ser_q, sr_q[7:1]};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      s_ser_q     <= 1'b1;
      prev_q      <= 1'b1;
      vld_q       <= '0;
      cnt_q       <= '0;
      bitcnt_q    <= '0;
      sr_q        <= '0;
      p_out_q     <= '0;
      p_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Synchronizer and edge history run regardless of rx_inh.
      sync1_q <= ser;
      s_ser_q <= sync1_q;
      prev_q  <= s_ser_q;
      vld_q   <= {vld_q[1:0], 1'b1};

      // Flags are exclusive: a frame is either bad or good, never both.
      frame_err_q <= bad_frame;
      overrun_q   <= good_frame && p_valid_q && !p_ready;

      // Output stage keeps working while receive is inhibited.
      if (good_frame && (!p_valid_q || p_ready)) begin
        p_out_q   <= sr_q;
        p_valid_q <= 1'b1;
      end else if (accept) begin
        p_valid_q <= 1'b0;
      end

      if (!rx_inh) begin
        case (state_q)
          IDLE: begin
            if (start_edge) begin
              state_q <= START;
              cnt_q   <= HALF_LOAD;
            end
          end
          START: begin
            if (cnt_exp) begin
              if (!s_ser_q) begin
                state_q  <= DATA;
                cnt_q    <= FULL_LOAD;
                bitcnt_q <= '0;
              end else begin
                // False start: line went back high before mid start bit.
                state_q <= IDLE;
                cnt_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          DATA: begin
            if (cnt_exp) begin
              sr_q  <= sr_d;
              cnt_q <= FULL_LOAD;
              if (bitcnt_q == 3'd7) begin
                state_q  <= STOP;
                bitcnt_q <= '0;
              end else begin
                bitcnt_q <= bitcnt_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          STOP: begin
            if (cnt_exp) begin
              // Back to IDLE straight away so a start edge on the next
              // cycle is caught.
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign p_out     = p_out_q;
  assign p_valid   = p_valid_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_sipo
//
// Directed bench for uart_rx_sipo at 16 clocks/bit. Two instances share all
// inputs: dut (MSB_FIRST=1) and dut_l (MSB_FIRST=0). Frames are always driven
// onto the line in the order b[7] first. A negedge monitor records busy and
// p_valid rise cycles, p_valid high cycles, and flag pulses. The directed steps
// compare these records against hand-computed values.
//
// Latency reference: the first cycle busy is seen high is the cycle the FSM
// is in START with the counter loaded. From there p_valid rises 152 cycles
// later (mid-stop decision at +151, output register loads on the next edge).
// -----------------------------------------------------------------------------
module tb_uart_rx_sipo;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       ser;
  logic       rx_inh;
  logic       p_ready;
  logic [7:0] p_out;
  logic       p_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic [1:0] dbg_state;
  logic [7:0] p_out_l;
  logic       p_valid_l;
  logic       busy_l;
  logic       frame_err_l;
  logic       overrun_l;
  logic [1:0] dbg_state_l;

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .clr(clr), .ser(ser), .rx_inh(rx_inh),
    .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  uart_rx_sipo #(.CLKS_PER_BIT(CPB), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr(clr), .ser(ser), .rx_inh(rx_inh),
    .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready),
    .busy(busy_l), .frame_err(frame_err_l), .overrun(overrun_l),
    .dbg_state(dbg_state_l)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Watchdog: the run must always end on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  int   busy_rise_cnt, first_busy_rise;
  int   pv_rise_cnt, first_pv_rise, pv_high_cnt;
  int   fe_cnt, ov_cnt, both_cnt;
  logic busy_prev = 1'b0;
  logic pv_prev   = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      if (busy_rise_cnt == 0) first_busy_rise = cyc;
      busy_rise_cnt++;
    end
    if (p_valid && !pv_prev) begin
      if (pv_rise_cnt == 0) first_pv_rise = cyc;
      pv_rise_cnt++;
    end
    if (p_valid)              pv_high_cnt++;
    if (frame_err)            fe_cnt++;
    if (overrun)              ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    busy_prev = busy;
    pv_prev   = p_valid;
  end

  task automatic clear_mon();
    busy_rise_cnt   = 0;
    first_busy_rise = -1;
    pv_rise_cnt     = 0;
    first_pv_rise   = -1;
    pv_high_cnt     = 0;
    fe_cnt          = 0;
    ov_cnt          = 0;
  endtask

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start bit, b[7]..b[0], stop bit (stop_b). If inh_at >= 0, at that
  // cycle of the frame rx_inh is raised and the line is frozen for inh_len
  // cycles, so the receiver should see the frame delayed by exactly inh_len.
  task automatic send_frame(input logic [7:0] b, input logic stop_b,
                            input int inh_at, input int inh_len);
    logic [9:0] fr;
    fr = {1'b0, b, stop_b};
    for (int c = 0; c < 10 * CPB; c++) begin
      if (c == inh_at) begin
        rx_inh = 1'b1;
        repeat (inh_len) @(negedge clk);
        rx_inh = 1'b0;
      end
      ser = fr[9 - c / CPB];
      @(negedge clk);
    end
    ser = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic seen;
    int   b_cyc;

    clr = 1'b1; ser = 1'b1; rx_inh = 1'b0; p_ready = 1'b1;
    clear_mon();
    both_cnt = 0;
    idle(3);

    // Reset state
    chk("rst_p_out",     32'(p_out),     32'h00);
    chk("rst_p_valid",   32'(p_valid),   32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun",   32'(overrun),   32'h0);
    chk("rst_state",     32'(dbg_state), 32'h0);

    // Line already low when clr releases: no start
    ser = 1'b0;
    idle(3);
    clr = 1'b0;
    clear_mon();
    idle(40);
    chk("low_after_clr_no_start", 32'(busy_rise_cnt), 32'd0);
    ser = 1'b1;
    idle(10);

    // 8'hA5, good stop, p_ready=1
    clear_mon();
    send_frame(8'hA5, 1'b1, -1, 0);
    idle(20);
    chk("a5_p_out",    32'(p_out), 32'hA5);
    chk("a5_pv_width", 32'(pv_high_cnt), 32'd1);
    chk("a5_latency",  32'(first_pv_rise - first_busy_rise), 32'd152);
    chk("a5_no_ferr",  32'(fe_cnt), 32'd0);

    // Bit order: 1,0,0,0,0,0,0,0
    clear_mon();
    send_frame(8'h80, 1'b1, -1, 0);
    idle(20);
    chk("order_msb_first", 32'(p_out),   32'h80);
    chk("order_lsb_first", 32'(p_out_l), 32'h01);

    // 4-cycle low glitch: false start
    clear_mon();
    ser = 1'b0;
    idle(4);
    ser = 1'b1;
    idle(30);
    chk("glitch_went_start", 32'(busy_rise_cnt), 32'd1);
    chk("glitch_state_idle", 32'(dbg_state),     32'd0);
    chk("glitch_no_valid",   32'(pv_rise_cnt),   32'd0);
    chk("glitch_no_ferr",    32'(fe_cnt),        32'd0);

    // Start edge while inhibited in IDLE is ignored
    clear_mon();
    rx_inh = 1'b1;
    ser = 1'b0;
    idle(20);
    ser = 1'b1;
    idle(5);
    rx_inh = 1'b0;
    idle(20);
    chk("inh_blocks_start", 32'(busy_rise_cnt), 32'd0);

    // 8'h3C with bad stop bit, then good 8'h5A
    clear_mon();
    send_frame(8'h3C, 1'b0, -1, 0);
    idle(4);
    chk("ferr_pulse_once", 32'(fe_cnt),      32'd1);
    chk("ferr_no_valid",   32'(pv_rise_cnt), 32'd0);
    send_frame(8'h5A, 1'b1, -1, 0);
    idle(20);
    chk("after_ferr_p_out", 32'(p_out),       32'h5A);
    chk("after_ferr_valid", 32'(pv_rise_cnt), 32'd1);
    chk("after_ferr_fe",    32'(fe_cnt),      32'd1);

    // Overrun: p_ready=0, 8'h11 then 8'h22 back-to-back
    p_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, -1, 0);
    send_frame(8'h22, 1'b1, -1, 0);
    idle(20);
    chk("ovr_pulse_once", 32'(ov_cnt),  32'd1);
    chk("ovr_p_out_kept", 32'(p_out),   32'h11);
    chk("ovr_valid_held", 32'(p_valid), 32'h1);
    p_ready = 1'b1;
    @(negedge clk);
    chk("ovr_drain_valid", 32'(p_valid), 32'h0);
    chk("ovr_drain_p_out", 32'(p_out),   32'h11);

    // Good frame completing on the very cycle the pending byte is taken
    p_ready = 1'b0;
    send_frame(8'h33, 1'b1, -1, 0);
    idle(5);
    chk("pend_p_out", 32'(p_out), 32'h33);
    clear_mon();
    seen = 1'b0;
    fork
      send_frame(8'h44, 1'b1, -1, 0);
      begin
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (busy) begin
            seen = 1'b1;
            break;
          end
        end
        if (seen) begin
          // Mid-stop decision is 151 cycles after this one; offer p_ready
          // only during that cycle.
          idle(151);
          p_ready = 1'b1;
          @(negedge clk);
          p_ready = 1'b0;
        end
      end
    join
    idle(10);
    chk("same_cyc_busy_seen", 32'(seen),    32'h1);
    chk("same_cyc_p_out",     32'(p_out),   32'h44);
    chk("same_cyc_valid",     32'(p_valid), 32'h1);
    chk("same_cyc_no_ovr",    32'(ov_cnt),  32'd0);
    p_ready = 1'b1;
    idle(5);

    // clr in the middle of data bit 4 of 8'h47 (line bits 0,1,0,0,0,1,1,1)
    clear_mon();
    fork
      send_frame(8'h47, 1'b1, -1, 0);
      begin
        idle(5 * CPB + 8);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_busy",    32'(busy),    32'h0);
        chk("clr_p_out",   32'(p_out),   32'h00);
        chk("clr_p_valid", 32'(p_valid), 32'h0);
        chk("clr_state",   32'(dbg_state), 32'd0);
        clr = 1'b0;
      end
    join
    b_cyc = busy_rise_cnt;
    idle(20);
    chk("clr_one_start_only", 32'(b_cyc),       32'd1);
    chk("clr_no_valid",       32'(pv_rise_cnt), 32'd0);
    chk("clr_no_ferr",        32'(fe_cnt),      32'd0);
    chk("clr_no_ovr",         32'(ov_cnt),      32'd0);
    chk("clr_idle_after",     32'(busy),        32'h0);
    clear_mon();
    send_frame(8'h96, 1'b1, -1, 0);
    idle(20);
    chk("post_clr_p_out", 32'(p_out),       32'h96);
    chk("post_clr_valid", 32'(pv_rise_cnt), 32'd1);

    // rx_inh for 100 cycles mid-frame (line frozen alongside)
    clear_mon();
    send_frame(8'hC3, 1'b1, 60, 100);
    idle(20);
    chk("inh_p_out",   32'(p_out), 32'hC3);
    chk("inh_latency", 32'(first_pv_rise - first_busy_rise), 32'd252);
    chk("inh_no_ferr", 32'(fe_cnt), 32'd0);

    chk("flags_never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_sipo.md
UART_RX_SIPO -- requirements
Module: uart_rx_sipo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal values are even integers 4..1024.
REQ-002 SHALL have parameter MSB_FIRST, default 1, where 1 means the first data bit received lands in p_out[7] and 0 means it lands in p_out[0].
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port ser  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port rx_inh  input  1  receive inhibit; high freezes the receive FSM and counters.
REQ-007 SHALL have port p_out  output  8  received byte, held stable while p_valid is high.
REQ-008 SHALL have port p_valid  output  1  byte available.
REQ-009 SHALL have port p_ready  input  1  consumer accepts the byte.
REQ-010 SHALL have port busy  output  1  high in any FSM state other than IDLE.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-013 SHALL pass ser through a 2-flop synchronizer (s_ser) before any use; all cycle counts below are relative to s_ser.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP; frame format is 8N1.
REQ-015 IDLE->START SHALL occur on an s_ser 1->0 transition; the bit counter loads CLKS_PER_BIT/2-1.
REQ-016 In START, at counter expiry (mid start bit): s_ser=0 SHALL go to DATA with counter=CLKS_PER_BIT-1; s_ser=1 SHALL go to IDLE as a false start, with no flags raised.
REQ-017 In DATA, SHALL sample s_ser at each counter expiry, 8 samples spaced CLKS_PER_BIT cycles apart, shifting into an internal shift register in the order set by MSB_FIRST; after the 8th sample SHALL go to STOP.
REQ-018 In STOP, at mid stop bit, s_ser=1 SHALL mark the frame good and s_ser=0 SHALL pulse frame_err the next cycle and discard the byte.
REQ-019 Both STOP outcomes SHALL go to IDLE, so a start edge arriving one cycle after the mid-stop sample is detected.
REQ-020 With CLKS_PER_BIT=16, the mid-stop sample SHALL occur 151 cycles after the start-edge detection cycle.
REQ-021 On a good frame with p_valid=0, p_out SHALL load and p_valid SHALL rise on the cycle after the mid-stop sample.
REQ-022 p_valid SHALL hold with p_out stable until a cycle where p_valid&&p_ready; p_valid SHALL drop the next cycle unless REQ-023 applies.
REQ-023 If a good frame completes in the same cycle as p_valid&&p_ready, the new byte SHALL load and p_valid SHALL stay 1.
REQ-024 If a good frame completes while p_valid=1 and p_ready=0, the new byte SHALL be dropped, p_out kept, and overrun pulsed for 1 cycle.
REQ-025 rx_inh=1 SHALL hold FSM state, counters and shift register unchanged, and SHALL block a start edge seen in IDLE.
REQ-026 The p_valid/p_ready handshake SHALL continue to operate while rx_inh=1.
REQ-027 The synchronizer SHALL run regardless of rx_inh.
REQ-028 The counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and SHALL never wrap; every expiry reloads it explicitly.
REQ-029 frame_err and overrun SHALL never both be high in the same cycle.

Reset
REQ-030 clr=1 at a clock edge SHALL force: FSM=IDLE, synchronizer flops=1, counters=0, shift register=0, p_out=8'h00, p_valid=0, busy=0, frame_err=0, overrun=0.
REQ-031 clr SHALL take priority over rx_inh, p_ready and all other inputs.
REQ-032 A frame in progress when clr asserts SHALL be abandoned with no flag raised.
REQ-033 After clr deasserts, a line held low SHALL NOT be treated as a start; a 1->0 edge is required.

Verification
REQ-034 CLKS_PER_BIT=16, MSB_FIRST=1, p_ready=1, send byte 8'hA5 MSB-first with a good stop bit -> p_out=8'hA5 and p_valid high for exactly 1 cycle, 152 cycles after the edge-detect cycle.
REQ-035 MSB_FIRST=0, send bits 1,0,0,0,0,0,0,0 in that order -> p_out=8'h01; with MSB_FIRST=1 the same bit sequence -> p_out=8'h80.
REQ-036 Low glitch of 4 cycles on ser -> state returns to IDLE after the mid-start sample, p_valid=0, frame_err=0.
REQ-037 Byte 8'h3C with the stop bit driven 0 -> frame_err 1-cycle pulse, p_valid stays 0, and the next good frame 8'h5A is received correctly.
REQ-038 p_ready=0, send 8'h11 then 8'h22 back-to-back -> p_out=8'h11 kept and overrun pulses once; then raising p_ready drops p_valid with p_out still 8'h11.
REQ-039 clr asserted mid-DATA at bit 4, and separately rx_inh held for 100 cycles mid-frame -> the clr case leaves all outputs at reset values and the next frame is received cleanly; the inhibit case receives the byte correctly, with output delayed by exactly 100 cycles.
